// File: rtl/button_dejitter_if.sv
// Button signal bundle: raw level toward the debouncer, clean level and edge strobes back.
// The master is the pin/board side, the slave is the debouncer.
interface button_dejitter_if;
  logic BTN_IN;
  logic BTN_OUT;
  logic BTN_RISE;
  logic BTN_FALL;

  modport master (
    output BTN_IN,
    input  BTN_OUT,
    input  BTN_RISE,
    input  BTN_FALL
  );

  modport slave (
    input  BTN_IN,
    output BTN_OUT,
    output BTN_RISE,
    output BTN_FALL
  );
endinterface

// File: rtl/button_dejitter.sv
// Push-button debouncer: two-flop synchronizer plus a stability counter.
// The output takes a new level only after COUNT_TO consecutive stable cycles, with one-cycle edge strobes.
module button_dejitter #(
  parameter int unsigned COUNT_TO = 250000
) (
  input  logic               CLK,
  input  logic               RST_N,
  button_dejitter_if.slave   btn
);

  localparam int unsigned   CW    = $clog2(COUNT_TO + 1);
  localparam logic [CW:0]   LIMIT = (CW + 1)'(COUNT_TO);
  localparam logic [CW:0]   ONE   = (CW + 1)'(1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW:0]   cnt_inc;

  // One extra bit on the increment keeps the terminal compare free of wrap.
  always_comb begin
    s1_d    = btn.BTN_IN;
    s2_d    = s1_q;
    cnt_inc = {1'b0, cnt_q} + ONE;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_inc >= LIMIT) begin
      cnt_d  = '0;
      out_d  = s2_q;
      rise_d = s2_q;
      fall_d = ~s2_q;
    end else begin
      cnt_d = cnt_inc[CW-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign btn.BTN_OUT  = out_q;
  assign btn.BTN_RISE = rise_q;
  assign btn.BTN_FALL = fall_q;

endmodule

// File: tb/tb_button_dejitter.sv
// Directed bench for button_dejitter with three instances: a scaled long window (50), the
// COUNT_TO = 4 boundary case and the COUNT_TO = 1 pass-through case.
module tb_button_dejitter;

  localparam int C0 = 50;
  localparam int C1 = 4;
  localparam int C2 = 1;

  logic CLK;
  logic RST_N;
  logic in_r   [3];
  logic out_w  [3];
  logic rise_w [3];
  logic fall_w [3];
  int   rise_cnt [3];
  int   fall_cnt [3];
  int   both_cnt;
  int   n_checks;
  int   n_errors;
  logic seen_hi;
  logic seen_lo;

  button_dejitter_if bi0 ();
  button_dejitter_if bi1 ();
  button_dejitter_if bi2 ();

  button_dejitter #(.COUNT_TO(C0)) dut0 (.CLK(CLK), .RST_N(RST_N), .btn(bi0.slave));
  button_dejitter #(.COUNT_TO(C1)) dut1 (.CLK(CLK), .RST_N(RST_N), .btn(bi1.slave));
  button_dejitter #(.COUNT_TO(C2)) dut2 (.CLK(CLK), .RST_N(RST_N), .btn(bi2.slave));

  assign bi0.BTN_IN = in_r[0];
  assign bi1.BTN_IN = in_r[1];
  assign bi2.BTN_IN = in_r[2];
  assign out_w[0]  = bi0.BTN_OUT;
  assign out_w[1]  = bi1.BTN_OUT;
  assign out_w[2]  = bi2.BTN_OUT;
  assign rise_w[0] = bi0.BTN_RISE;
  assign rise_w[1] = bi1.BTN_RISE;
  assign rise_w[2] = bi2.BTN_RISE;
  assign fall_w[0] = bi0.BTN_FALL;
  assign fall_w[1] = bi1.BTN_FALL;
  assign fall_w[2] = bi2.BTN_FALL;

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Strobe tallies sampled mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (rise_w[i] === 1'b1) rise_cnt[i]++;
      if (fall_w[i] === 1'b1) fall_cnt[i]++;
      if (rise_w[i] === 1'b1 && fall_w[i] === 1'b1) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int idx, input logic level, input int cycles);
    in_r[idx] = level;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (out_w[idx] === 1'b1) seen_hi = 1'b1;
      if (out_w[idx] === 1'b0) seen_lo = 1'b1;
    end
  endtask

  // Ticks until the output reaches target or max ticks elapse; n is the tick count.
  task automatic wait_out(input int idx, input logic target, input int max, output int n);
    n = 0;
    while (n < max && out_w[idx] !== target) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int r0, f0;
    n_checks = 0;
    n_errors = 0;
    both_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      in_r[i]     = 1'b0;
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    seen_hi = 1'b0;
    seen_lo = 1'b0;

    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #4;
    check("reset out0",  out_w[0],  0);
    check("reset rise0", rise_w[0], 0);
    check("reset fall0", fall_w[0], 0);
    check("reset out1",  out_w[1],  0);
    check("reset out2",  out_w[2],  0);
    #95 RST_N = 1'b1;
    tick();

    // Long window: press then release, each measured from the first sampling edge.
    r0 = rise_cnt[0]; f0 = fall_cnt[0];
    in_r[0] = 1'b1;
    wait_out(0, 1'b1, 200, n);
    check("A rise latency", n, C0 + 2);
    check("A rise aligned", rise_w[0], 1);
    drive(0, 1'b1, 10);
    check("A out high", out_w[0], 1);
    check("A rise pulses", rise_cnt[0] - r0, 1);
    check("A no fall", fall_cnt[0] - f0, 0);
    in_r[0] = 1'b0;
    wait_out(0, 1'b0, 200, n);
    check("A fall latency", n, C0 + 2);
    check("A fall aligned", fall_w[0], 1);
    drive(0, 1'b0, 10);
    check("A fall pulses", fall_cnt[0] - f0, 1);

    // Press with a gap: count restarts, nothing reaches the output.
    r0 = rise_cnt[0]; f0 = fall_cnt[0]; seen_hi = 1'b0;
    drive(0, 1'b1, 40);
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 30);
    drive(0, 1'b0, 60);
    check("B out stayed 0", seen_hi, 0);
    check("B no rise", rise_cnt[0] - r0, 0);
    check("B no fall", fall_cnt[0] - f0, 0);

    // Release glitches while held: output stays high.
    drive(0, 1'b1, 60);
    check("C pressed", out_w[0], 1);
    r0 = rise_cnt[0]; f0 = fall_cnt[0]; seen_lo = 1'b0;
    drive(0, 1'b0, 40);
    drive(0, 1'b1, 10);
    drive(0, 1'b0, 30);
    drive(0, 1'b1, 60);
    check("C out stayed 1", seen_lo, 0);
    check("C no rise", rise_cnt[0] - r0, 0);
    check("C no fall", fall_cnt[0] - f0, 0);

    // COUNT_TO = 4 boundary: 3 high cycles rejected.
    r0 = rise_cnt[1]; seen_hi = 1'b0;
    drive(1, 1'b1, 3);
    drive(1, 1'b0, 10);
    check("D 3 cycles out", seen_hi, 0);
    check("D 3 cycles rise", rise_cnt[1] - r0, 0);

    // 4 high cycles: output rises exactly at edge k+5.
    r0 = rise_cnt[1]; f0 = fall_cnt[1];
    drive(1, 1'b1, 4);
    in_r[1] = 1'b0;
    tick();
    check("D k+4 still 0", out_w[1], 0);
    tick();
    check("D k+5 out", out_w[1], 1);
    check("D k+5 rise", rise_w[1], 1);
    drive(1, 1'b0, 12);
    check("D settles low", out_w[1], 0);
    check("D rise pulses", rise_cnt[1] - r0, 1);
    check("D fall pulses", fall_cnt[1] - f0, 1);

    // Single-cycle low glitch after 3 high cycles must clear the count.
    r0 = rise_cnt[1]; seen_hi = 1'b0;
    drive(1, 1'b1, 3);
    drive(1, 1'b0, 1);
    drive(1, 1'b1, 3);
    drive(1, 1'b0, 10);
    check("D glitch out", seen_hi, 0);
    check("D glitch rise", rise_cnt[1] - r0, 0);

    // Reset mid-count on dut1 (counter at 2) while dut0 holds BTN_OUT = 1.
    drive(1, 1'b1, 4);
    check("E dut0 high", out_w[0], 1);
    #3 RST_N = 1'b0;
    #1;
    check("E async out0", out_w[0], 0);
    check("E async out1", out_w[1], 0);
    check("E async rise1", rise_w[1], 0);
    check("E async fall1", fall_w[1], 0);
    #10 RST_N = 1'b1;
    wait_out(1, 1'b1, 50, n);
    check("E relatch latency", n, C1 + 2);
    drive(1, 1'b0, 10);

    // COUNT_TO = 1 follows the synchronized input one cycle later.
    in_r[2] = 1'b1;
    wait_out(2, 1'b1, 20, n);
    check("F rise latency", n, C2 + 2);
    check("F rise aligned", rise_w[2], 1);
    drive(2, 1'b1, 3);
    in_r[2] = 1'b0;
    wait_out(2, 1'b0, 20, n);
    check("F fall latency", n, C2 + 2);
    drive(2, 1'b0, 3);
    r0 = rise_cnt[2]; f0 = fall_cnt[2];
    drive(2, 1'b1, 1);
    drive(2, 1'b0, 6);
    check("F pulse rise", rise_cnt[2] - r0, 1);
    check("F pulse fall", fall_cnt[2] - f0, 1);
    check("F pulse settle", out_w[2], 0);

    check("strobes never both", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_dejitter.md
Name: button_dejitter

Overview:
- Debounces (dejitters) a single mechanical push-button input.
- BTN_OUT takes a new level only after the synchronized input has held that level for COUNT_TO consecutive clock cycles, in both press and release directions.
- Also emits one-cycle press/release strobes.
- Sits between a raw board pin and user logic. Runs in the single system clock domain.

Parameters:
- COUNT_TO, 250000, stability window in clock cycles; legal range 1 to 2^24. At a 20 ns clock, 250000 = 5 ms.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- BTN_IN  input  1  raw, asynchronous, bouncing button level (1 = pressed).
- BTN_OUT  output  1  debounced level, registered.
- BTN_RISE  output  1  one-cycle strobe when BTN_OUT goes 0->1.
- BTN_FALL  output  1  one-cycle strobe when BTN_OUT goes 1->0.

Behaviour:
- Reset (RST_N=0, asynchronous, no clock needed):
  - sync flops = 0
  - counter = 0
  - BTN_OUT = 0, BTN_RISE = 0, BTN_FALL = 0
  - Deassertion takes effect on the next rising edge.
- Synchronizer: two-stage flop chain BTN_IN -> s1 -> s2. Only s2 is used downstream.
- Counter: width ceil(log2(COUNT_TO+1)) bits, unsigned. Each rising edge:
  - s2 == BTN_OUT: counter <= 0.
  - s2 != BTN_OUT and counter+1 < COUNT_TO: counter <= counter+1.
  - s2 != BTN_OUT and counter+1 == COUNT_TO: BTN_OUT <= s2, counter <= 0, and the matching strobe is registered high for that one cycle.
- Strobes: otherwise BTN_RISE = BTN_FALL = 0. Never both high. Each is high for exactly one cycle per BTN_OUT transition, aligned with the BTN_OUT change.
- Latency: BTN_IN sampled at edge k and held → BTN_OUT changes at edge k+COUNT_TO+1.
  - Held exactly COUNT_TO sampled cycles → transition occurs.
  - Held COUNT_TO-1 cycles → no transition.
- Glitches:
  - Any return of s2 to BTN_OUT's level clears the counter. Partial counts never accumulate across glitches.
  - A change shorter than COUNT_TO cycles is fully rejected, including release glitches while BTN_OUT = 1.
- No wrap: the counter never exceeds COUNT_TO-1.
- COUNT_TO = 1: BTN_OUT follows s2 with one cycle delay.
- Reset mid-count: count is lost; output returns to 0.
- Input held constant: outputs static, no strobes.
- No combinational path from BTN_IN to any output.

Test Plan:
- Clock 20 ns, COUNT_TO = 250000, hold RST_N = 0 for 100 ns then release, BTN_IN = 1 for 6 ms
  -> BTN_OUT rises 250001 edges after the first sampling edge (≈5.00002 ms); BTN_RISE high exactly 1 cycle.
- Then BTN_IN = 0 for 6 ms
  -> BTN_OUT falls ≈5 ms later; BTN_FALL pulses once.
- From BTN_OUT = 0: BTN_IN = 1 for 4 ms, 0 for 1 ms, 1 for 3 ms, then 0
  -> BTN_OUT stays 0, no strobes (count restarts after the gap).
- From BTN_OUT = 1: BTN_IN = 0 for 4 ms, 1 for 1 ms, 0 for 3 ms, then 1
  -> BTN_OUT stays 1, no strobes.
- COUNT_TO = 4 boundary check:
  - BTN_IN high for 3 clock cycles -> no change.
  - BTN_IN high for 4 cycles -> BTN_OUT = 1 at edge k+5.
  - Single-cycle 0 glitch after 3 high cycles -> counter cleared, no transition.
- Reset mid-operation: RST_N pulsed low, asynchronous to CLK, while the counter is partway (e.g. at 2 with COUNT_TO = 4) or while BTN_OUT = 1
  -> all outputs 0 immediately; after release with BTN_IN = 1, a full COUNT_TO+1 edges are needed before BTN_OUT = 1.
